// File: rtl/silu_pkg.sv
// Shared constants, word payload type and requantization helpers for the SiLU requant/pack block.
package silu_pkg;

  localparam int unsigned ACT_W          = 16;
  localparam int unsigned ACT_FRAC       = 8;
  localparam int unsigned Q_W            = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned PROD_W         = 25;
  localparam int          Q_MIN          = -128;
  localparam int          Q_MAX          = 127;

  // Shift range covers twice the fractional bits (0..15)
  localparam int unsigned SHIFT_W = $clog2(2 * ACT_FRAC);
  // One guard bit above the product so the rounding add cannot wrap
  localparam int unsigned REQ_W   = PROD_W + 1;
  localparam int unsigned CNT_W   = $clog2(BYTES_PER_WORD);
  localparam int unsigned HOLD_W  = (BYTES_PER_WORD - 1) * Q_W;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } word_t;

  localparam int unsigned FIFO_W = $bits(word_t);

  function automatic logic [Q_W-1:0] sat_q8(input logic signed [REQ_W-1:0] v);
    if (v > REQ_W'(Q_MAX)) return Q_W'(Q_MAX);
    if (v < REQ_W'(Q_MIN)) return Q_W'(Q_MIN);
    return v[Q_W-1:0];
  endfunction

  function automatic logic clipped(input logic signed [REQ_W-1:0] v);
    return (v > REQ_W'(Q_MAX)) || (v < REQ_W'(Q_MIN));
  endfunction

endpackage

// File: rtl/silu_requant_pack_if.sv
// Packed-word output stream (valid/ready) from the requant packer to the memory writer.
interface silu_requant_pack_if;
  import silu_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_last;

  modport master (output out_valid, output out_data, output out_last, input  out_ready);
  modport slave  (input  out_valid, input  out_data, input  out_last, output out_ready);
endinterface

// File: rtl/silu_sync_fifo.sv
// First-word-fall-through FIFO; a push while full without a pop is dropped and flagged.
module silu_sync_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   pop_valid,
  output logic [$clog2(DEPTH):0] count_nxt_c,
  output logic                   drop_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    drop_c   = push && !do_push;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // Head is gated so stale storage never shows while empty
  assign pop_valid   = (count_q != '0);
  assign pop_data    = pop_valid ? mem_q[rd_ptr_q] : '0;
  assign count_nxt_c = count_d;

endmodule

// File: rtl/silu_requant_pack.sv
// Requantizes Q8.8 SiLU samples to int8, packs 4 per word and buffers them in a FWFT FIFO.
// Optional saturation counter enabled by defining SILU_SAT_CNT_EN.
module silu_requant_pack
  import silu_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned AFULL_MARGIN = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [ACT_W-1:0]   in_data,
  input  logic               in_last,
  input  logic [Q_W-1:0]     cfg_scale,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic [Q_W-1:0]     cfg_zp,
  output logic               in_afull,
  output logic               busy,
  output logic               ovf,
  output logic [15:0]        sat_cnt,
  silu_requant_pack_if.master out_if
);

  localparam int unsigned CW        = $clog2(DEPTH) + 1;
  localparam int unsigned AFULL_LVL = DEPTH - AFULL_MARGIN;

  logic                     s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic signed [PROD_W-1:0] s1_prod_q, s1_prod_d;
  logic [SHIFT_W-1:0]       s1_shift_q, s1_shift_d;
  logic signed [Q_W-1:0]    s1_zp_q, s1_zp_d;
  logic                     s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
  logic [Q_W-1:0]           s2_byte_q, s2_byte_d, s2_zp_q, s2_zp_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [HOLD_W-1:0]        hold_q, hold_d;
  logic                     in_afull_q, in_afull_d, ovf_q, ovf_d;
  logic signed [REQ_W-1:0]  rnd_c, req_c, v_c;
  logic [WORD_W-1:0]        word_c;
  logic                     push_c, fifo_valid, fifo_drop;
  logic [CW-1:0]            fifo_cnt_nxt;
  word_t                    push_word, pop_word;

  always_comb begin
    s1_valid_d = in_valid;
    s1_last_d  = in_valid && in_last;
    s1_prod_d  = PROD_W'($signed(in_data) * $signed({1'b0, cfg_scale}));
    s1_shift_d = cfg_shift;
    s1_zp_d    = cfg_zp;

    // Round half up, then arithmetic shift, then add zero point
    rnd_c = $signed({s1_prod_q[PROD_W-1], s1_prod_q});
    if (s1_shift_q != '0) rnd_c = rnd_c + (REQ_W'(1) << (s1_shift_q - SHIFT_W'(1)));
    req_c = rnd_c >>> s1_shift_q;
    v_c   = req_c + REQ_W'(s1_zp_q);

    s2_valid_d = s1_valid_q;
    s2_last_d  = s1_last_q;
    s2_byte_d  = sat_q8(v_c);
    s2_zp_d    = s1_zp_q;

    // Unfilled upper bytes take the zero point when a row closes early
    case (cnt_q)
      2'd0:    word_c = {s2_zp_q, s2_zp_q, s2_zp_q, s2_byte_q};
      2'd1:    word_c = {s2_zp_q, s2_zp_q, s2_byte_q, hold_q[7:0]};
      2'd2:    word_c = {s2_zp_q, s2_byte_q, hold_q[15:0]};
      default: word_c = {s2_byte_q, hold_q};
    endcase

    push_c = 1'b0;
    cnt_d  = cnt_q;
    hold_d = hold_q;
    if (s2_valid_q) begin
      if ((cnt_q == CNT_W'(BYTES_PER_WORD - 1)) || s2_last_q) begin
        push_c = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        case (cnt_q)
          2'd0:    hold_d[7:0]   = s2_byte_q;
          2'd1:    hold_d[15:8]  = s2_byte_q;
          default: hold_d[23:16] = s2_byte_q;
        endcase
      end
    end

    push_word  = '{last: s2_last_q, data: word_c};
    ovf_d      = ovf_q | fifo_drop;
    in_afull_d = (fifo_cnt_nxt >= CW'(AFULL_LVL));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_prod_q  <= '0;
      s1_shift_q <= '0;
      s1_zp_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_byte_q  <= '0;
      s2_zp_q    <= '0;
      cnt_q      <= '0;
      hold_q     <= '0;
      in_afull_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_prod_q  <= s1_prod_d;
      s1_shift_q <= s1_shift_d;
      s1_zp_q    <= s1_zp_d;
      s2_valid_q <= s2_valid_d;
      s2_last_q  <= s2_last_d;
      s2_byte_q  <= s2_byte_d;
      s2_zp_q    <= s2_zp_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      in_afull_q <= in_afull_d;
      ovf_q      <= ovf_d;
    end
  end

  silu_sync_fifo #(.WIDTH(FIFO_W), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push_c),
    .push_data   (push_word),
    .pop         (out_if.out_ready),
    .pop_data    (pop_word),
    .pop_valid   (fifo_valid),
    .count_nxt_c (fifo_cnt_nxt),
    .drop_c      (fifo_drop)
  );

`ifdef SILU_SAT_CNT_EN
  logic        s2_sat_q, s2_sat_d;
  logic [15:0] sat_cnt_q, sat_cnt_d;

  // Counts every clipped S2 byte, including ones later dropped on overflow
  always_comb begin
    s2_sat_d  = s1_valid_q && clipped(v_c);
    sat_cnt_d = sat_cnt_q;
    if (s2_valid_q && s2_sat_q && (sat_cnt_q != 16'hFFFF)) sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_sat_q  <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      s2_sat_q  <= s2_sat_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt = sat_cnt_q;
`else
  assign sat_cnt = 16'h0;
`endif

  assign out_if.out_valid = fifo_valid;
  assign out_if.out_data  = pop_word.data;
  assign out_if.out_last  = pop_word.last;
  assign in_afull         = in_afull_q;
  assign ovf              = ovf_q;
  assign busy             = s1_valid_q | s2_valid_q | (cnt_q != '0) | fifo_valid;

endmodule

// File: tb/tb_silu_requant_pack.sv
// Directed bench for silu_requant_pack: latency, rounding, saturation, padding, backpressure, reset.
module tb_silu_requant_pack;
  import silu_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic [ACT_W-1:0]   in_data = '0;
  logic               in_last = 1'b0;
  logic [Q_W-1:0]     cfg_scale = 8'd1;
  logic [SHIFT_W-1:0] cfg_shift = 4'd4;
  logic [Q_W-1:0]     cfg_zp = 8'd0;
  logic               in_afull, busy, ovf;
  logic [15:0]        sat_cnt;

  int checks = 0;
  int errors = 0;

  silu_requant_pack_if out_if();

  silu_requant_pack #(.DEPTH(8), .AFULL_MARGIN(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .cfg_scale (cfg_scale),
    .cfg_shift (cfg_shift),
    .cfg_zp    (cfg_zp),
    .in_afull  (in_afull),
    .busy      (busy),
    .ovf       (ovf),
    .sat_cnt   (sat_cnt),
    .out_if    (out_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_word(input int k);
    for (int j = 0; j < 4; j++) send(16'(4 * k + j), 1'b0);
  endtask

  function automatic logic [31:0] seq_word(input int k);
    return {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)};
  endfunction

  task automatic configure(input logic [7:0] s, input logic [3:0] sh, input logic [7:0] z);
    cfg_scale = s;
    cfg_shift = sh;
    cfg_zp    = z;
  endtask

  // Waits (bounded) for a word, checks it, then pops it
  task automatic expect_word(input string tag, input logic [31:0] data, input logic last);
    int n = 0;
    while (!out_if.out_valid && n < 16) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(out_if.out_valid), 32'd1);
    check({tag, "_data"}, out_if.out_data, data);
    check({tag, "_last"}, 32'(out_if.out_last), 32'(last));
    out_if.out_ready = 1'b1;
    tick();
    out_if.out_ready = 1'b0;
  endtask

  initial begin
    out_if.out_ready = 1'b0;
    idle(2);
    check("rst_valid", 32'(out_if.out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_afull", 32'(in_afull), 32'd0);
    check("rst_satcnt", 32'(sat_cnt), 32'd0);
    check("rst_data", out_if.out_data, 32'd0);
    rst = 1'b1;
    tick();

    // Basic packing and 3-cycle latency
    send(16'h0100, 1'b0);
    send(16'h0200, 1'b0);
    send(16'hFF00, 1'b0);
    send(16'h0000, 1'b0);
    check("t1_lat1", 32'(out_if.out_valid), 32'd0);
    tick();
    check("t1_lat2", 32'(out_if.out_valid), 32'd0);
    tick();
    check("t1_lat3", 32'(out_if.out_valid), 32'd1);
    check("t1_data", out_if.out_data, 32'h00F02010);
    check("t1_last", 32'(out_if.out_last), 32'd0);
    out_if.out_ready = 1'b1;
    tick();
    out_if.out_ready = 1'b0;
    check("t1_empty", 32'(out_if.out_valid), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);

    // Rounding half up
    send(16'h0018, 1'b0);
    send(16'hFFE8, 1'b0);
    send(16'h0008, 1'b0);
    send(16'hFFF8, 1'b0);
    expect_word("t2", 32'h0001FF02, 1'b0);

    // Saturation, closed early by last
    idle(2);
    configure(8'd255, 4'd0, 8'd0);
    send(16'h7FFF, 1'b0);
    send(16'h8000, 1'b1);
    expect_word("t3", 32'h0000807F, 1'b1);
`ifdef SILU_SAT_CNT_EN
    check("t3_satcnt", 32'(sat_cnt), 32'd2);
`else
    check("t3_satcnt", 32'(sat_cnt), 32'd0);
`endif

    // Partial row padded with zero point; last on 4th byte gives a single word
    idle(2);
    configure(8'd1, 4'd4, 8'd5);
    send(16'h0100, 1'b0);
    send(16'h0200, 1'b1);
    expect_word("t4", 32'h05052515, 1'b1);
    send(16'h0100, 1'b0);
    send(16'h0100, 1'b0);
    send(16'h0100, 1'b0);
    send(16'h0100, 1'b1);
    expect_word("t4_full", 32'h15151515, 1'b1);
    idle(4);
    check("t4_nopad", 32'(out_if.out_valid), 32'd0);

    // Backpressure, almost-full threshold, overflow and in-order drain
    configure(8'd1, 4'd0, 8'd0);
    for (int k = 0; k < 5; k++) send_word(k);
    idle(4);
    check("t5_afull_at5", 32'(in_afull), 32'd0);
    send_word(5);
    idle(4);
    check("t5_afull_at6", 32'(in_afull), 32'd1);
    check("t5_ovf_at6", 32'(ovf), 32'd0);
    send_word(6);
    send_word(7);
    idle(4);
    check("t5_ovf_at8", 32'(ovf), 32'd0);
    for (int k = 8; k < 16; k++) send_word(k);
    idle(4);
    check("t5_ovf_set", 32'(ovf), 32'd1);
    out_if.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("t5_drain_valid", 32'(out_if.out_valid), 32'd1);
      check("t5_drain_data", out_if.out_data, seq_word(k));
      tick();
    end
    out_if.out_ready = 1'b0;
    check("t5_drained", 32'(out_if.out_valid), 32'd0);
    check("t5_afull_clr", 32'(in_afull), 32'd0);
    check("t5_ovf_sticky", 32'(ovf), 32'd1);

    // Reset with a partial word and a non-empty FIFO
    for (int k = 0; k < 3; k++) send_word(k);
    send(16'h0011, 1'b0);
    send(16'h0022, 1'b0);
    idle(3);
    check("t6_busy_pre", 32'(busy), 32'd1);
    rst = 1'b0;
    tick();
    check("t6_valid", 32'(out_if.out_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_ovf", 32'(ovf), 32'd0);
    check("t6_data", out_if.out_data, 32'd0);
    check("t6_satcnt", 32'(sat_cnt), 32'd0);
    rst = 1'b1;
    send(16'h0011, 1'b0);
    send(16'h0022, 1'b0);
    send(16'h0033, 1'b0);
    send(16'h0044, 1'b0);
    expect_word("t6_new", 32'h44332211, 1'b0);
    idle(4);
    check("t6_single", 32'(out_if.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
